// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder and its decode counterpart.
//   fmt_e     : instruction format selector (values 6 and 7 are illegal)
//   Opc*      : RV32I major opcodes
//   Err*      : err_code values reported by the encoder
//   FifoDepth : output FIFO depth; PtrW/CntW derived pointer and count widths
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FmtR = 3'd0,
        FmtI = 3'd1,
        FmtS = 3'd2,
        FmtB = 3'd3,
        FmtU = 3'd4,
        FmtJ = 3'd5
    } fmt_e;

    localparam logic [6:0] OpcLoad   = 7'h03;
    localparam logic [6:0] OpcOpImm  = 7'h13;
    localparam logic [6:0] OpcAuipc  = 7'h17;
    localparam logic [6:0] OpcStore  = 7'h23;
    localparam logic [6:0] OpcOp     = 7'h33;
    localparam logic [6:0] OpcLui    = 7'h37;
    localparam logic [6:0] OpcBranch = 7'h63;
    localparam logic [6:0] OpcJalr   = 7'h67;
    localparam logic [6:0] OpcJal    = 7'h6f;
    localparam logic [6:0] OpcSystem = 7'h73;

    localparam logic [2:0] ErrNone     = 3'd0;
    localparam logic [2:0] ErrImmRange = 3'd1;
    localparam logic [2:0] ErrShamt    = 3'd2;
    localparam logic [2:0] ErrBRange   = 3'd3;
    localparam logic [2:0] ErrJRange   = 3'd4;
    localparam logic [2:0] ErrAlign    = 3'd5;
    localparam logic [2:0] ErrULow     = 3'd6;
    localparam logic [2:0] ErrFmt      = 3'd7;

    localparam int unsigned FifoDepth = 4;
    localparam int unsigned PtrW      = $clog2(FifoDepth);
    localparam int unsigned CntW      = PtrW + 1;

    // True when imm, read as a signed 32-bit value, lies within [lo, hi].
    function automatic logic imm_in_range(logic [31:0] imm, int lo, int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-set input handshake and encoded-word output handshake of the encoder.
//   master : producer of field sets / consumer of words (testbench, upstream logic)
//   slave  : the encoder
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, instr_out
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, instr_out
    );
endinterface

// File: rtl/instr_fifo.sv
// 4x32 first-word-fall-through FIFO for encoded instruction words.
//   clk, reset : clock, asynchronous active-low reset
//   push/wdata : write wdata at the tail (ignored when full)
//   pop        : drop the head word (ignored when empty)
//   rdata      : head word; while empty, the last word popped (0 after reset)
//   empty/full : occupancy flags; count : occupancy 0..FifoDepth
module instr_fifo
    import instr_encoder_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [31:0]     wdata,
    input  logic            pop,
    output logic [31:0]     rdata,
    output logic            empty,
    output logic            full,
    output logic [CntW-1:0] count
);

    logic [31:0]     mem_q [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [31:0]     last_q;
    logic            push_ok;
    logic            pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(FifoDepth));
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Holding the last popped word keeps the output steady across empty periods.
    assign rdata = empty ? last_q : mem_q[rd_ptr_q];

    // Storage needs no reset: an entry is only visible after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CntW'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: places fields per format, range-checks the immediate,
// and queues legal words in a 4-entry FWFT FIFO.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : field-set input and encoded-word output handshakes
//   err_clr    : clear the sticky error on the next edge (a new error wins)
//   err        : sticky error flag; err_code : first error cause while err=1
//   count      : FIFO occupancy; enc_total : words enqueued since reset (wraps)
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    instr_encoder_if.slave   bus,
    input  logic             err_clr,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CntW-1:0]  count,
    output logic [15:0]      enc_total
);

    fmt_e        fmt;
    logic [31:0] imm;
    logic [31:0] word;
    logic [2:0]  code;
    logic        is_shift;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        fifo_full;

    logic        err_q;
    logic [2:0]  err_code_q;
    logic [15:0] enc_total_q;

    assign fmt      = fmt_e'(bus.fmt);
    assign imm      = bus.imm;
    assign is_shift = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);

    always_comb begin
        word = '0;
        code = ErrNone;
        case (fmt)
            FmtR: begin
                word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            end
            FmtI: begin
                if (is_shift) begin
                    // Shift amount is unsigned; negative values count as too large.
                    word = {bus.funct7, imm[4:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                    if (imm > 32'd31) begin
                        code = ErrShamt;
                    end
                end else begin
                    word = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                    if (!imm_in_range(imm, -2048, 2047)) begin
                        code = ErrImmRange;
                    end
                end
            end
            FmtS: begin
                word = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
                if (!imm_in_range(imm, -2048, 2047)) begin
                    code = ErrImmRange;
                end
            end
            FmtB: begin
                word = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3, imm[4:1], imm[11],
                        bus.opcode};
                if (!imm_in_range(imm, -4096, 4094)) begin
                    code = ErrBRange;
                end else if (imm[0]) begin
                    code = ErrAlign;
                end
            end
            FmtU: begin
                word = {imm[31:12], bus.rd, bus.opcode};
                if (imm[11:0] != 12'd0) begin
                    code = ErrULow;
                end
            end
            FmtJ: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
                if (!imm_in_range(imm, -1048576, 1048574)) begin
                    code = ErrJRange;
                end else if (imm[0]) begin
                    code = ErrAlign;
                end
            end
            default: begin
                code = ErrFmt;
            end
        endcase
    end

    assign bus.in_ready  = !fifo_full;
    assign bus.out_valid = !fifo_empty;
    assign accept        = bus.in_valid && !fifo_full;
    assign push          = accept && (code == ErrNone);
    assign pop           = bus.out_ready && !fifo_empty;

    instr_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (word),
        .pop   (pop),
        .rdata (bus.instr_out),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q       <= 1'b0;
            err_code_q  <= ErrNone;
            enc_total_q <= '0;
        end else begin
            if (accept && (code != ErrNone)) begin
                err_q <= 1'b1;
                // Keep the first cause unless this same edge also clears it.
                if (!err_q || err_clr) begin
                    err_code_q <= code;
                end
            end else if (err_clr) begin
                err_q      <= 1'b0;
                err_code_q <= ErrNone;
            end
            if (push) begin
                enc_total_q <= enc_total_q + 16'd1;
            end
        end
    end

    assign err       = err_q;
    assign err_code  = err_code_q;
    assign enc_total = enc_total_q;

endmodule
